// File: rtl/sar_controller_pkg.sv
// rtl/sar_controller_pkg.sv - state encoding and default width for the SAR controller
package sar_controller_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2,
      DONE   = 2'd3
   } sar_state_t;

   localparam int SAR_DEFAULT_N = 8;

endpackage

// File: rtl/sar_controller.sv
// rtl/sar_controller.sv - successive-approximation conversion controller
// Optional feature: SAR_CONTROLLER_ABORT_EN lets go=0 abandon a conversion in SAMPLE/CONV.
module sar_controller
   import sar_controller_pkg::*;
#(
   parameter int N = SAR_DEFAULT_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         go,
   output logic         valid,
   output logic [N-1:0] result,
   output logic         sample,
   output logic [N-1:0] value,
   input  logic         cmp
);

   sar_state_t   state;
   logic [N-1:0] mask;
   logic         abort;

`ifdef SAR_CONTROLLER_ABORT_EN
   assign abort = ~go;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         result <= '0;
         mask   <= '0;
         sample <= 1'b0;
         valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state  <= SAMPLE;
                  sample <= 1'b1;
               end
            end
            SAMPLE: begin
               sample <= 1'b0;
               if (abort) begin
                  state <= IDLE;
               end else begin
                  state  <= CONV;
                  result <= '0;
                  mask   <= {1'b1, {(N-1){1'b0}}};
               end
            end
            CONV: begin
               if (abort) begin
                  state <= IDLE;
                  mask  <= '0;
               end else begin
                  // the bit under trial is kept only if the held input reaches the trial code
                  if (cmp) result <= result | mask;
                  mask <= mask >> 1;
                  if (mask[0]) begin
                     state <= DONE;
                     valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (!go) begin
                  state <= IDLE;
                  valid <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               sample <= 1'b0;
               valid  <= 1'b0;
            end
         endcase
      end
   end

   assign value = (state == SAMPLE || state == CONV) ? (result | mask) : result;

endmodule

// File: tb/tb_sar_controller.sv
// tb/tb_sar_controller.sv - randomized self-checking bench for sar_controller
module tb_sar_controller;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         go;
   logic         valid;
   logic [N-1:0] result;
   logic         sample;
   logic [N-1:0] value;
   logic         cmp;
   logic [N-1:0] ain;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   // ideal comparator against the held analog input
   assign cmp = (ain >= value);

   sar_controller #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (go),
      .valid  (valid),
      .result (result),
      .sample (sample),
      .value  (value),
      .cmp    (cmp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // full conversion of input a; go raised at a negedge, checks sampled at negedges
   task automatic convert(input logic [N-1:0] a, input bit keep_go);
      logic [N-1:0] decided;
      logic [N-1:0] trial;
      ain = a;
      go  = 1'b1;
      @(negedge clk);
      check("sample_pulse", {31'b0, sample}, 32'd1);
      check("valid_in_sample", {31'b0, valid}, 32'd0);
      decided = '0;
      for (int b = N - 1; b >= 0; b--) begin
         @(negedge clk);
         trial = decided | (N'(1) << b);
         check("conv_value", {24'b0, value}, {24'b0, trial});
         check("conv_flags", {30'b0, sample, valid}, 32'd0);
         if (a >= trial) decided = trial;
      end
      @(negedge clk);
      check("valid_latency", {31'b0, valid}, 32'd1);
      check("result", {24'b0, result}, {24'b0, a});
      if (!keep_go) begin
         go = 1'b0;
         @(negedge clk);
         check("valid_drop", {31'b0, valid}, 32'd0);
         check("result_hold_idle", {24'b0, result}, {24'b0, a});
         check("idle_value", {24'b0, value}, {24'b0, a});
      end
   endtask

   initial begin
      logic [N-1:0] a;
      int seen;
      rst_n = 1'b0;
      go    = 1'b1;
      ain   = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_sample", {31'b0, sample}, 32'd0);
      check("rst_result", {24'b0, result}, 32'd0);
      check("rst_value", {24'b0, value}, 32'd0);
      rst_n = 1'b1;
      go    = 1'b0;
      @(negedge clk);
      check("idle_no_sample", {31'b0, sample}, 32'd0);

      convert(8'h46, 1'b0);
      convert(8'hFF, 1'b0);
      convert(8'h00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         a = N'($urandom_range(0, (1 << N) - 1));
         convert(a, 1'b0);
      end

      // hold go high in DONE: result frozen, no restart
      a = N'($urandom_range(0, (1 << N) - 1));
      convert(a, 1'b1);
      for (int i = 0; i < 200; i++) begin
         ain = ~a;
         @(negedge clk);
         check("hold_valid", {31'b0, valid}, 32'd1);
         check("hold_result", {24'b0, result}, {24'b0, a});
         check("hold_no_sample", {31'b0, sample}, 32'd0);
      end
      go = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("release_valid", {31'b0, valid}, 32'd0);
      end
      a = N'($urandom_range(0, (1 << N) - 1));
      convert(a, 1'b0);

      // reset during the 4th CONV cycle
      ain = N'($urandom_range(0, (1 << N) - 1));
      go  = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_result", {24'b0, result}, 32'd0);
      check("midrst_valid", {31'b0, valid}, 32'd0);
      check("midrst_sample", {31'b0, sample}, 32'd0);
      check("midrst_value", {24'b0, value}, 32'd0);
      rst_n = 1'b1;
      go    = 1'b0;
      @(negedge clk);
      check("midrst_idle", {30'b0, sample, valid}, 32'd0);

      // drop go in CONV
      a   = N'($urandom_range(0, (1 << N) - 1));
      ain = a;
      go  = 1'b1;
      @(negedge clk);
      check("abort_sample", {31'b0, sample}, 32'd1);
      @(negedge clk);
      go = 1'b0;
      seen = 0;
`ifdef SAR_CONTROLLER_ABORT_EN
      @(negedge clk);
      check("abort_flags", {30'b0, sample, valid}, 32'd0);
      repeat (12) begin
         @(negedge clk);
         if (valid) seen = 1;
      end
      check("abort_no_valid", seen, 0);
`else
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (valid) seen = 1;
      end
      check("noabort_valid", seen, 1);
      check("noabort_result", {24'b0, result}, {24'b0, a});
      @(negedge clk);
      check("noabort_valid_1cyc", {31'b0, valid}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 The block SHALL have a parameter N, default 8: conversion width in bits; legal range N >= 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port go, input, 1 bit: conversion request level.
REQ-005 Port valid, output, 1 bit: result is complete and stable.
REQ-006 Port result, output, N bits: conversion result register.
REQ-007 Port sample, output, 1 bit: sample-and-hold strobe to the analog front end.
REQ-008 Port value, output, N bits: trial code driven to the DAC.
REQ-009 Port cmp, input, 1 bit: comparator output; 1 means held input >= value.

Function
REQ-010 The block SHALL implement a Moore FSM with states IDLE, SAMPLE, CONV and DONE, plus an N-bit one-hot register named mask.
- IDLE: if go=1, next state is SAMPLE; otherwise it stays in IDLE.
- SAMPLE: lasts exactly one cycle; result <= 0; mask <= 1 at MSB (bit N-1); next state is CONV.
- CONV, each cycle: if cmp=1, result <= result | mask; then mask <= mask >> 1; when mask has bit 0 set, next state is DONE.
- DONE: stays in DONE while go=1; go=0 returns the FSM to IDLE.
REQ-011 sample SHALL be 1 only in SAMPLE. valid SHALL be 1 only in DONE. Both SHALL be registered-state decodes with no combinational path from go.
REQ-012 value SHALL be result | mask in SAMPLE and CONV, and result in IDLE and DONE.
- cmp SHALL be sampled only in CONV.
REQ-013 Latency: with go=1 at edge E, the FSM SHALL enter SAMPLE at E, CONV at E+1 and DONE at E+N+1.
- For N=8, valid rises after edge E+9.
REQ-014 result SHALL hold its value through DONE and IDLE until the next SAMPLE clears it.
REQ-015 When go stays high in DONE, the block SHALL NOT start a new conversion; go must drop to 0 for at least one cycle first.
REQ-016 Boundary codes: cmp always 1 SHALL yield result all-ones; cmp always 0 SHALL yield result 0.
REQ-017 For CONV cycles after the first, value SHALL already contain every bit decided in earlier CONV cycles.

Reset
REQ-018 When rst_n=0 at a clk edge, the block SHALL set: state IDLE, result 0, mask 0, sample 0, valid 0, value 0.
REQ-019 Reset SHALL override go in every state, including mid-CONV; no partial result remains after reset.

Configuration
REQ-020 With macro SAR_CONTROLLER_ABORT_EN defined, go=0 in SAMPLE or CONV SHALL return the FSM to IDLE at the next edge.
- valid stays 0 on abort; result keeps its partial value.
REQ-021 Without SAR_CONTROLLER_ABORT_EN, go SHALL be ignored in SAMPLE and CONV, and the conversion always completes to DONE.

Structure
REQ-022 Package sar_controller_pkg SHALL hold:
- the state enum (IDLE, SAMPLE, CONV, DONE);
- the default width constant (8).
REQ-023 The block SHALL be a single module with no sub-module; the FSM and the result/mask datapath share one clocked process plus combinational output decode.

Verification
REQ-024 Nominal: rst_n pulse, then go=1; model cmp = (8'h46 >= value).
- Required: sample high for exactly 1 cycle; value sequence 80,40,60,50,48,44,46,47; result = 8'h46; valid high 9 edges after go is sampled.
REQ-025 Extremes: model cmp with held input 8'hFF, then 8'h00.
- Required: result = 8'hFF and 8'h00 respectively; valid asserts on both runs.
REQ-026 Hold in DONE: keep go=1 for 200 cycles after valid.
- Required: valid stays 1 and result is stable; no second sample pulse.
- Then go=0 for 2 cycles followed by go=1. Required: valid drops, and a new sample pulse and conversion follow.
REQ-027 Reset mid-conversion: assert rst_n=0 during the 4th CONV cycle.
- Required: at the next edge, state IDLE, result 0, valid 0, sample 0.
REQ-028 Abort: drop go to 0 in CONV.
- With SAR_CONTROLLER_ABORT_EN: the FSM is in IDLE next cycle and valid never asserts.
- Without it: the conversion finishes and valid asserts for one cycle before the FSM returns to IDLE.
